uart_tx_arbiter: RTL and testbench

Round-robin arbiter/sequencer that shares one UART transmitter among NREQ byte sources. It accepts bytes over per-requester valid/ready handshakes and issues one tx_start pulse per byte. It holds the shared tx_din stable until the transmitter reports tx_done_tick. Multi-byte packets are kept contiguous: the current owner keeps the transmitter until it sends a byte flagged last. The block sits between client logic and the existing tx core, which is paced by baud_rate.

---
 rtl/uart_tx_arbiter_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } arb_state_t;

  localparam int UART_DBIT = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle for the UART tx arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DBIT = UART_DBIT
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner search with packet-lock override.
module uart_rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  input  logic            i_lock,
  input  logic [PW-1:0]   i_owner,
  output logic [PW-1:0]   o_winner,
  output logic            o_found
);

  logic [PW-1:0] w_pos;

  always_comb begin
    o_winner = i_owner;
    o_found  = 1'b0;
    w_pos    = '0;
    if (i_lock) begin
      o_found = i_req[i_owner];
    end else begin
      // farthest first, so the nearest slot after the pointer wins
      for (int k = NREQ; k >= 1; k--) begin
        w_pos = PW'((int'(i_rr_ptr) + k) % NREQ);
        if (i_req[w_pos]) begin
          o_winner = w_pos;
          o_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte sources, keeping packets whole.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DBIT = UART_DBIT
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_din,
  input  logic             tx_done_tick,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic            r_lock;
  logic            r_last;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_ptr;
  logic [DBIT-1:0] r_din;
  logic [NREQ-1:0] r_grant;

  logic [PW-1:0]   w_winner;
  logic            w_found;
  logic            w_accept;
  logic [NREQ-1:0] w_onehot;
  logic [DBIT-1:0] w_data;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req_valid),
    .i_rr_ptr (r_ptr),
    .i_lock   (r_lock),
    .i_owner  (r_owner),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  assign bus.req_ready =
    (r_state == IDLE && w_found && !rst) ? w_onehot : '0;
  assign w_accept = |(bus.req_valid & bus.req_ready);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == PW'(i)) begin
        w_data = bus.req_data[i*DBIT +: DBIT];
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    tx_start = 1'b0;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = START;
      START: begin
        tx_start = 1'b1;
        w_next   = WAIT;
      end
      WAIT:    if (tx_done_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lock  <= 1'b0;
      r_last  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_din   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_winner;
        r_din   <= w_data;
        r_last  <= bus.req_last[w_winner];
        r_grant <= w_onehot;
      end
      // an unfinished packet keeps the transmitter for its owner
      if (r_state == WAIT && tx_done_tick) begin
        r_grant <= '0;
        r_lock  <= !r_last;
        if (r_last) r_ptr <= r_owner;
      end
    end
  end

  assign tx_din = r_din;
  assign grant  = r_grant;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural tx core.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int PW   = 2;
  localparam int TMO  = 400;

  typedef struct packed {
    logic [DBIT-1:0] d;
    logic [NREQ-1:0] g;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx_done_tick = 1'b0;
  logic [NREQ-1:0] grant;
  logic            busy;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  ent_t sb[$];
  ent_t tx_log[$];

  logic [NREQ-1:0] acc_neg = '0;
  int core_lo  = 1;
  int core_hi  = 6;
  int core_cnt = 0;
  bit spur_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DBIT-1:0] get_data(input logic [PW-1:0] i);
    get_data = '0;
    for (int j = 0; j < NREQ; j++)
      if (PW'(j) == i) get_data = bus.req_data[j*DBIT +: DBIT];
  endfunction

  task automatic set_data(input logic [PW-1:0] i, input logic [DBIT-1:0] d);
    for (int j = 0; j < NREQ; j++)
      if (PW'(j) == i) bus.req_data[j*DBIT +: DBIT] = d;
  endtask

  // Present one byte and hold it until the arbiter takes it.
  task automatic send(input logic [PW-1:0] i, input logic [DBIT-1:0] d,
                      input logic l);
    int n;
    n = 0;
    bus.req_valid[i] = 1'b1;
    bus.req_last[i]  = l;
    set_data(i, d);
    do begin
      tick();
      n++;
    end while (!acc_neg[i] && n < TMO);
    if (!acc_neg[i]) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: req %0d got no accept, required accept", i);
    end
  endtask

  task automatic fair(input logic [PW-1:0] i);
    send(i, 8'h10 | {6'b0, i}, 1'b1);
    send(i, 8'h10 | {6'b0, i}, 1'b1);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick();
    while (busy && n < TMO) begin
      tick();
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  // tx core stand-in: one done pulse a random delay after each start
  initial forever begin
    tick();
    tx_done_tick = 1'b0;
    if (tx_start) begin
      core_cnt = $urandom_range(core_hi, core_lo);
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) tx_done_tick = 1'b1;
    end
    if (spur_en && $urandom_range(5, 0) == 0) tx_done_tick = 1'b1;
  end

  always @(negedge clk) acc_neg = bus.req_valid & bus.req_ready;

  // Reference: who should be served next, and what the outputs must show
  logic            m_busy  = 1'b0;
  logic            m_start = 1'b0;
  logic            m_lock  = 1'b0;
  logic            m_last  = 1'b0;
  logic [PW-1:0]   m_cur   = '0;
  logic [PW-1:0]   m_rr    = PW'(NREQ - 1);
  logic [DBIT-1:0] m_din   = '0;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] hits;
    logic [PW-1:0]   j;
    exp_rdy = '0;
    exp_g   = '0;
    j       = '0;
    if (m_busy) exp_g[m_cur] = 1'b1;
    check("busy", busy, m_busy);
    check("grant", grant, exp_g);
    check("tx_start", tx_start, m_start);
    check("tx_din", tx_din, m_din);
    if (!rst && !m_busy) begin
      if (m_lock) begin
        exp_rdy[m_cur] = bus.req_valid[m_cur];
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          j = PW'((int'(m_rr) + k) % NREQ);
          if (exp_rdy == '0 && bus.req_valid[j]) exp_rdy[j] = 1'b1;
        end
      end
    end
    check("req_ready", bus.req_ready, exp_rdy);
    hits = bus.req_valid & exp_rdy;
    if (rst) begin
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_lock  = 1'b0;
      m_last  = 1'b0;
      m_cur   = '0;
      m_rr    = PW'(NREQ - 1);
      m_din   = '0;
    end else if (hits != '0) begin
      for (int k = 0; k < NREQ; k++) if (hits[k]) m_cur = PW'(k);
      m_din   = get_data(m_cur);
      m_last  = bus.req_last[m_cur];
      m_busy  = 1'b1;
      m_start = 1'b1;
      sb.push_back('{d: m_din, g: hits});
    end else if (m_busy) begin
      if (m_start) begin
        m_start = 1'b0;
      end else if (tx_done_tick) begin
        m_busy = 1'b0;
        if (m_last) begin
          m_lock = 1'b0;
          m_rr   = m_cur;
        end else begin
          m_lock = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    ent_t e;
    if (tx_start === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_start: got tx_start, required none pending");
      end else begin
        e = sb.pop_front();
        check("sb_din", tx_din, e.d);
        check("sb_grant", grant, e.g);
      end
      tx_log.push_back('{d: tx_din, g: grant});
    end
  end

  task automatic rand_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_neg[i] || (!bus.req_valid[i] && $urandom_range(3, 0) == 0)) begin
          if (acc_neg[i] && $urandom_range(1, 0) == 0) begin
            bus.req_valid[i] = 1'b0;
          end else begin
            bus.req_valid[i] = 1'b1;
            bus.req_last[i]  = 1'($urandom_range(1, 0));
            set_data(PW'(i), 8'($urandom));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    int n;
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_data  = '0;
    for (int i = 0; i < NREQ; i++) set_data(PW'(i), 8'hE0 | 8'(i));
    repeat (3) tick();
    check("rst_ready", bus.req_ready, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, '0);
    check("rst_start", tx_start, 1'b0);
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (acc_neg == '0 && n < 50);
    check("first_acc", acc_neg, 4'b0001);
    bus.req_valid = '0;
    wait_idle("first_idle");
    check("first_tx", tx_log[0], {8'hE0, 4'b0001});

    tx_log.delete();
    send(2'd1, 8'h5A, 1'b1);
    bus.req_valid[1] = 1'b0;
    wait_idle("single_idle");
    check("single_n", tx_log.size(), 1);
    check("single_tx", tx_log[0], {8'h5A, 4'b0010});

    tx_log.delete();
    fork
      begin
        send(2'd0, 8'h3C, 1'b1);
        bus.req_valid[0] = 1'b0;
      end
      begin
        send(2'd2, 8'hA5, 1'b0);
        bus.req_valid[2] = 1'b0;
        repeat (20) begin
          tick();
          check("lock_rdy0", bus.req_ready[0], 1'b0);
        end
        send(2'd2, 8'hC3, 1'b1);
        bus.req_valid[2] = 1'b0;
      end
    join
    wait_idle("lock_idle");
    check("lock_n", tx_log.size(), 3);
    check("lock_tx0", tx_log[0], {8'hA5, 4'b0100});
    check("lock_tx1", tx_log[1], {8'hC3, 4'b0100});
    check("lock_tx2", tx_log[2], {8'h3C, 4'b0001});

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_log.delete();
    fork
      fair(2'd0);
      fair(2'd1);
      fair(2'd2);
      fair(2'd3);
    join
    wait_idle("fair_idle");
    check("fair_n", tx_log.size(), 8);
    for (int k = 0; k < 8; k++)
      check("fair_order", tx_log[k].d, 8'(16 + k % 4));

    core_lo = 10;
    core_hi = 12;
    tx_log.delete();
    send(2'd3, 8'h77, 1'b1);
    bus.req_valid[3] = 1'b0;
    tick();
    tick();
    check("midwait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_grant", grant, '0);
    repeat (16) begin
      tick();
      check("stray_busy", busy, 1'b0);
    end
    core_lo = 1;
    core_hi = 6;
    fork
      begin
        send(2'd2, 8'h22, 1'b1);
        bus.req_valid[2] = 1'b0;
      end
      begin
        send(2'd0, 8'h44, 1'b1);
        bus.req_valid[0] = 1'b0;
      end
    join
    wait_idle("midrst_idle");
    check("midrst_n", tx_log.size(), 3);
    check("midrst_tx0", tx_log[0], {8'h77, 4'b1000});
    check("midrst_tx1", tx_log[1], {8'h44, 4'b0001});
    check("midrst_tx2", tx_log[2], {8'h22, 4'b0100});

    core_hi = 10;
    spur_en = 1'b1;
    rand_phase(3000);
    bus.req_valid = '0;
    spur_en = 1'b0;
    wait_idle("rand_idle");
    tick();
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
